dlf_gearshift_pi: RTL and testbench

- Second-generation digital loop filter for the ADPLL. Sits between the phase-error quantizer and the DCO.
- Proportional-integral filter with power-of-two gains, so no multipliers. Widths are parametrised and the integrator saturates.
- A gear-shift FSM switches from wide-bandwidth acquisition gains to narrow tracking gains and raises a lock flag. A freeze/hold mode and a synchronous restart are also provided.
- Output is an offset-binary DCO control word with a valid strobe.

---
 rtl/dlf_gearshift_pi.sv | 205 ++++++++++++++++++++
 tb/tb_dlf_gearshift_pi.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dlf_gearshift_pi.sv
`default_nettype none
// ============================================================================
// Module   : dlf_gearshift_pi
// Brief    : ADPLL PI loop filter with power-of-two gains, a saturating
//            integrator and an ACQ/TRACK/HOLD gear-shift controller.
// Revision : 1.0  initial release
// ============================================================================
module dlf_gearshift_pi #(
   parameter int IN_W       = 8,
   parameter int OUT_W      = 10,
   parameter int FRAC_W     = 12,
   parameter int KP_ACQ     = 2,
   parameter int KI_ACQ     = 4,
   parameter int KP_TRK     = 4,
   parameter int KI_TRK     = 8,
   parameter int ACQ_CYCLES = 256,
   parameter int LOCK_THR   = 4,
   parameter int LOCK_CNT   = 64
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic [IN_W-1:0]  err_mag,
   input  logic             lead,
   input  logic             err_valid,
   input  logic             freeze,
   input  logic             restart,
   output logic [OUT_W-1:0] dco_word,
   output logic             dco_valid,
   output logic [1:0]       gear,
   output logic             locked,
   output logic             sat
);

   localparam int c_iw  = OUT_W + FRAC_W;
   localparam int c_ew  = c_iw + 1;
   localparam int c_acw = $clog2(ACQ_CYCLES + 1);
   localparam int c_lcw = $clog2(LOCK_CNT + 1);

   localparam logic [c_iw-1:0]  c_i_hi     = {1'b0, {(c_iw-1){1'b1}}};
   localparam logic [c_iw-1:0]  c_i_lo     = {1'b1, {(c_iw-1){1'b0}}};
   localparam logic [OUT_W-1:0] c_mid      = {1'b1, {(OUT_W-1){1'b0}}};
   localparam logic [c_acw-1:0] c_acq_last = c_acw'(ACQ_CYCLES - 1);
   localparam logic [c_lcw-1:0] c_lock_max = c_lcw'(LOCK_CNT);
   localparam logic [c_lcw-1:0] c_lock_pre = c_lcw'(LOCK_CNT - 1);
   localparam logic [IN_W+1:0]  c_thr      = (IN_W+2)'(LOCK_THR);
   localparam logic [IN_W+1:0]  c_thr4     = (IN_W+2)'(4 * LOCK_THR);

   typedef enum logic [1:0] {
      ST_ACQ  = 2'd0,
      ST_TRK  = 2'd1,
      ST_HOLD = 2'd2
   } state_t;

   state_t r_state, w_state_nxt;
   state_t r_saved, w_saved_nxt;

   logic [c_acw-1:0] r_acq_cnt, w_acq_nxt;
   logic [c_lcw-1:0] r_lock_cnt, w_lock_nxt;
   logic             r_locked, w_locked_nxt;

   logic signed [c_iw-1:0] r_int;
   logic signed [IN_W:0]   r_e;
   logic                   r_v1;
   logic                   r_s1;
   logic                   r_kp_trk;

   logic signed [IN_W:0]   w_e;
   logic signed [c_ew-1:0] w_e_ext, w_p_ext, w_ki, w_kp, w_isum, w_ssum;
   logic [c_iw:0]          w_icl, w_scl;
   logic [IN_W+1:0]        w_mag_ext;
   logic                   w_take;
   logic                   w_unused_frac;

   // Result is {clip_flag, value}; a sum is out of range when its two MSBs differ.
   function automatic logic [c_iw:0] f_clamp(input logic signed [c_ew-1:0] s);
      logic [c_iw:0] res;
      if (s[c_ew-1] != s[c_ew-2]) begin
         res = {1'b1, (s[c_ew-1] ? c_i_lo : c_i_hi)};
      end else begin
         res = {1'b0, s[c_iw-1:0]};
      end
      return res;
   endfunction

   assign w_e       = lead ? $signed({1'b0, err_mag}) : -$signed({1'b0, err_mag});
   assign w_mag_ext = {2'b00, err_mag};
   assign w_take    = err_valid & ~freeze & (r_state != ST_HOLD);

   assign w_e_ext = $signed({{(c_ew-IN_W-1-FRAC_W){w_e[IN_W]}}, w_e, {FRAC_W{1'b0}}});
   assign w_p_ext = $signed({{(c_ew-IN_W-1-FRAC_W){r_e[IN_W]}}, r_e, {FRAC_W{1'b0}}});

   assign w_ki = (r_state == ST_TRK) ? (w_e_ext >>> KI_TRK) : (w_e_ext >>> KI_ACQ);
   assign w_kp = r_kp_trk ? (w_p_ext >>> KP_TRK) : (w_p_ext >>> KP_ACQ);

   assign w_isum = $signed({r_int[c_iw-1], r_int}) + w_ki;
   assign w_ssum = $signed({r_int[c_iw-1], r_int}) + w_kp;
   assign w_icl  = f_clamp(w_isum);
   assign w_scl  = f_clamp(w_ssum);

   // Fraction bits of the output sum are truncated away.
   assign w_unused_frac = ^w_scl[FRAC_W-1:0];

   assign gear   = r_state;
   assign locked = r_locked;

   always_comb begin
      w_state_nxt  = r_state;
      w_saved_nxt  = r_saved;
      w_acq_nxt    = r_acq_cnt;
      w_lock_nxt   = r_lock_cnt;
      w_locked_nxt = r_locked;
      if (restart) begin
         w_state_nxt  = ST_ACQ;
         w_acq_nxt    = '0;
         w_lock_nxt   = '0;
         w_locked_nxt = 1'b0;
      end else if (freeze) begin
         if (r_state != ST_HOLD) begin
            w_saved_nxt = r_state;
            w_state_nxt = ST_HOLD;
         end
      end else if (r_state == ST_HOLD) begin
         w_state_nxt = r_saved;
      end else if (err_valid) begin
         if (r_state == ST_ACQ) begin
            if (r_acq_cnt == c_acq_last) begin
               w_state_nxt = ST_TRK;
               w_acq_nxt   = '0;
               w_lock_nxt  = '0;
            end else begin
               w_acq_nxt = r_acq_cnt + c_acw'(1);
            end
         end else if (r_locked && (w_mag_ext > c_thr4)) begin
            // Large error while locked: fall back to acquisition gains.
            w_state_nxt  = ST_ACQ;
            w_acq_nxt    = '0;
            w_lock_nxt   = '0;
            w_locked_nxt = 1'b0;
         end else if (w_mag_ext <= c_thr) begin
            if (r_lock_cnt != c_lock_max) begin
               w_lock_nxt = r_lock_cnt + c_lcw'(1);
            end
            if (r_lock_cnt == c_lock_pre) begin
               w_locked_nxt = 1'b1;
            end
         end else begin
            w_lock_nxt = '0;
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state    <= ST_ACQ;
         r_saved    <= ST_ACQ;
         r_acq_cnt  <= '0;
         r_lock_cnt <= '0;
         r_locked   <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_saved    <= w_saved_nxt;
         r_acq_cnt  <= w_acq_nxt;
         r_lock_cnt <= w_lock_nxt;
         r_locked   <= w_locked_nxt;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_int     <= '0;
         r_e       <= '0;
         r_v1      <= 1'b0;
         r_s1      <= 1'b0;
         r_kp_trk  <= 1'b0;
         dco_word  <= c_mid;
         dco_valid <= 1'b0;
         sat       <= 1'b0;
      end else if (restart) begin
         r_int     <= '0;
         r_e       <= '0;
         r_v1      <= 1'b0;
         r_s1      <= 1'b0;
         r_kp_trk  <= 1'b0;
         dco_word  <= c_mid;
         dco_valid <= 1'b0;
         sat       <= 1'b0;
      end else begin
         r_v1 <= w_take;
         if (w_take) begin
            r_e      <= w_e;
            r_int    <= $signed(w_icl[c_iw-1:0]);
            r_s1     <= w_icl[c_iw];
            r_kp_trk <= (r_state == ST_TRK);
         end
         dco_valid <= r_v1;
         // Stage 2 runs off the integrator value already holding this sample.
         if (r_v1) begin
            dco_word <= {~w_scl[c_iw-1], w_scl[c_iw-2:FRAC_W]};
            sat      <= r_s1 | w_scl[c_iw];
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_dlf_gearshift_pi.sv
`default_nettype none
// ============================================================================
// Module   : tb_dlf_gearshift_pi
// Brief    : Scoreboard bench for dlf_gearshift_pi against a behavioural model.
// Revision : 1.0  initial release
// ============================================================================
module tb_dlf_gearshift_pi;

   localparam longint I_HI = (longint'(1) <<< 21) - 1;
   localparam longint I_LO = -(longint'(1) <<< 21);

   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   logic [7:0] err_mag = '0;
   logic       lead = 1'b0;
   logic       err_valid = 1'b0;
   logic       freeze = 1'b0;
   logic       restart = 1'b0;
   logic [9:0] dco_word;
   logic       dco_valid;
   logic [1:0] gear;
   logic       locked;
   logic       sat;

   always #5 clk = ~clk;

   dlf_gearshift_pi dut (
      .clk       (clk),
      .rstn      (rstn),
      .err_mag   (err_mag),
      .lead      (lead),
      .err_valid (err_valid),
      .freeze    (freeze),
      .restart   (restart),
      .dco_word  (dco_word),
      .dco_valid (dco_valid),
      .gear      (gear),
      .locked    (locked),
      .sat       (sat)
   );

   typedef struct {
      int word;
      int sat;
   } exp_t;

   exp_t sb[$];
   int   n_chk = 0;
   int   n_err = 0;

   longint m_i;
   int     m_gear, m_saved, m_acq, m_lockc, m_locked, m_v1, m_word;

   task automatic chk(input string tag, input longint obs, input longint exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic longint clampv(input longint v, output bit hit);
      hit = (v > I_HI) || (v < I_LO);
      if (v > I_HI) return I_HI;
      if (v < I_LO) return I_LO;
      return v;
   endfunction

   task automatic model_reset();
      m_i = 0; m_gear = 0; m_saved = 0; m_acq = 0; m_lockc = 0;
      m_locked = 0; m_v1 = 0; m_word = 512;
      sb.delete();
   endtask

   // One clock: drive at negedge, advance the model at posedge, compare just after.
   task automatic cyc(input bit ev, input bit ld, input int mag, input bit frz, input bit rs);
      bit     exp_valid, take, c1, c2;
      int     e;
      longint ee, ki, kp, ni, sv;
      exp_t   x;
      @(negedge clk);
      err_valid = ev; lead = ld; err_mag = 8'(mag); freeze = frz; restart = rs;
      @(posedge clk);
      exp_valid = 1'b0;
      if (rs) begin
         model_reset();
      end else begin
         exp_valid = (m_v1 != 0);
         take = ev && !frz && (m_gear != 2);
         if (take) begin
            e  = ld ? mag : -mag;
            ee = longint'(e) * 4096;
            ki = ee >>> ((m_gear == 1) ? 8 : 4);
            kp = ee >>> ((m_gear == 1) ? 4 : 2);
            ni = clampv(m_i + ki, c1);
            sv = clampv(ni + kp, c2);
            x.word = int'((sv >>> 12) + 512);
            x.sat  = (c1 || c2) ? 1 : 0;
            sb.push_back(x);
            m_i = ni;
         end
         if (frz) begin
            if (m_gear != 2) begin m_saved = m_gear; m_gear = 2; end
         end else if (m_gear == 2) begin
            m_gear = m_saved;
         end else if (take) begin
            if (m_gear == 0) begin
               if (m_acq == 255) begin m_gear = 1; m_acq = 0; m_lockc = 0; end
               else m_acq++;
            end else if (m_locked != 0 && mag > 16) begin
               m_locked = 0; m_gear = 0; m_acq = 0; m_lockc = 0;
            end else if (mag <= 4) begin
               if (m_lockc < 64) m_lockc++;
               if (m_lockc == 64) m_locked = 1;
            end else begin
               m_lockc = 0;
            end
         end
         m_v1 = take ? 1 : 0;
      end
      #1;
      chk("valid", dco_valid, exp_valid);
      if (exp_valid) begin
         if (sb.size() == 0) begin
            chk("sb_size", sb.size(), 1);
         end else begin
            x = sb.pop_front();
            chk("word", dco_word, x.word);
            chk("sat", sat, x.sat);
            m_word = x.word;
         end
      end else begin
         chk("hold_word", dco_word, m_word);
      end
      chk("gear", gear, m_gear);
      chk("locked", locked, m_locked);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 0, 1'b0, 1'b0);
   endtask

   task automatic do_restart();
      cyc(1'b0, 1'b0, 0, 1'b0, 1'b1);
   endtask

   task automatic do_reset_mid();
      @(negedge clk);
      #2 rstn = 1'b0;
      #1;
      chk("rst_word", dco_word, 512);
      chk("rst_valid", dco_valid, 0);
      chk("rst_gear", gear, 0);
      chk("rst_locked", locked, 0);
      chk("rst_sat", sat, 0);
      model_reset();
      err_valid = 1'b0; freeze = 1'b0; restart = 1'b0;
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      idle(3);
   endtask

   int prev;
   int nv;
   int hold_word;

   initial begin
      model_reset();
      repeat (3) @(negedge clk);
      chk("init_word", dco_word, 512);
      chk("init_valid", dco_valid, 0);
      chk("init_gear", gear, 0);
      rstn = 1'b1;
      idle(2);

      // Single-sample step response in each direction.
      cyc(1'b1, 1'b1, 16, 1'b0, 1'b0);
      idle(1);
      chk("t2_lead_word", dco_word, 517);
      chk("t2_lead_valid", dco_valid, 1);
      chk("t2_lead_sat", sat, 0);
      idle(1);
      do_restart();
      cyc(1'b1, 1'b0, 16, 1'b0, 1'b0);
      idle(1);
      chk("t2_lag_word", dco_word, 507);
      idle(1);

      // Reset dropped while samples are in flight.
      for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 40 + i, 1'b0, 1'b0);
      do_reset_mid();

      // Saturation under a sustained maximum error, then reversal.
      do_restart();
      prev = 512;
      for (int i = 0; i < 40; i++) begin
         cyc(1'b1, 1'b1, 255, 1'b0, 1'b0);
         if (dco_valid) begin
            chk("t3_mono", (int'(dco_word) >= prev) ? 1 : 0, 1);
            prev = int'(dco_word);
         end
      end
      chk("t3_clip_word", dco_word, 1023);
      chk("t3_clip_sat", sat, 1);
      cyc(1'b1, 1'b0, 255, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 255, 1'b0, 1'b0);
      chk("t3_reverse", (dco_word < 10'd1023) ? 1 : 0, 1);
      idle(2);

      // Gear shift to TRACK, lock, and loss of lock.
      do_restart();
      for (int i = 0; i < 255; i++) cyc(1'b1, 1'b1, 0, 1'b0, 1'b0);
      chk("t4_still_acq", gear, 0);
      cyc(1'b1, 1'b1, 0, 1'b0, 1'b0);
      chk("t4_track", gear, 1);
      for (int i = 0; i < 63; i++) cyc(1'b1, 1'b0, 0, 1'b0, 1'b0);
      chk("t4_not_yet", locked, 0);
      cyc(1'b1, 1'b0, 0, 1'b0, 1'b0);
      chk("t4_locked", locked, 1);
      cyc(1'b1, 1'b1, 17, 1'b0, 1'b0);
      chk("t4_unlock", locked, 0);
      chk("t4_back_acq", gear, 0);
      idle(2);

      // Freeze during streaming.
      do_restart();
      for (int i = 0; i < 20; i++) cyc(1'b1, 1'b1, $urandom_range(0, 60), 1'b0, 1'b0);
      nv = 0;
      for (int i = 0; i < 10; i++) begin
         cyc(1'b1, $urandom_range(0, 1), $urandom_range(0, 255), 1'b1, 1'b0);
         if (i == 0) hold_word = int'(dco_word);
         if (dco_valid) nv++;
         chk("t5_hold_gear", gear, 2);
         chk("t5_hold_word", dco_word, hold_word);
      end
      chk("t5_inflight", (nv <= 1) ? 1 : 0, 1);
      cyc(1'b1, 1'b1, 30, 1'b0, 1'b0);
      chk("t5_restored", gear, 0);
      for (int i = 0; i < 10; i++) cyc(1'b1, $urandom_range(0, 1), $urandom_range(0, 60), 1'b0, 1'b0);

      // Restart beats freeze and a valid sample in the same cycle.
      cyc(1'b1, 1'b1, 50, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, 50, 1'b1, 1'b1);
      chk("t6_word", dco_word, 512);
      chk("t6_gear", gear, 0);
      chk("t6_valid", dco_valid, 0);
      idle(1);
      chk("t6_no_strobe", dco_valid, 0);

      // Random mix.
      for (int i = 0; i < 400; i++) begin
         cyc(($urandom_range(0, 9) < 7), $urandom_range(0, 1),
             ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 8),
             ($urandom_range(0, 19) == 0), ($urandom_range(0, 99) == 0));
      end
      idle(3);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
`default_nettype wire
